// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, latency and FSM encoding for the Booth multiplier sequencer.
package mul_pkg;
  localparam int WIDTH       = 34;
  localparam int MUL_LATENCY = 24;
  localparam int CNT_W       = 5;
  localparam int PW          = 2 * WIDTH;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CAPT  = 2'd3;
  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    ISSUE = S_ISSUE,
    WAIT  = S_WAIT,
    CAPT  = S_CAPT
  } state_t;
endpackage

// File: rtl/mul_out_reg.sv
// mul_out_reg: product holding register with the valid/ready update rule.
module mul_out_reg
  import mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap_req,
  input  logic [PW-1:0] cap_d,
  input  logic          out_ready,
  output logic          cap_ok,
  output logic          out_valid,
  output logic [PW-1:0] out_p
);
  logic          out_valid_d, out_valid_q;
  logic [PW-1:0] out_p_d, out_p_q;
  always_comb begin
    cap_ok      = !out_valid_q || out_ready;
    out_valid_d = (cap_req && cap_ok) || (out_valid_q && !out_ready);
    out_p_d     = (cap_req && cap_ok) ? cap_d : out_p_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
endmodule

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: issues operand pairs to signed_multiplier, waits its fixed
// latency and captures the product into a valid/ready output register.
module booth_mul_sequencer
  import mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [PW-1:0]    mul_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    out_p,
  output logic             busy
);
  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] mul_a_d, mul_a_q, mul_b_d, mul_b_q;
  logic             cap_req, cap_ok;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    in_ready  = rst_n && (state_q == IDLE);
    mul_start = state_q == ISSUE;
    busy      = state_q != IDLE;
    cap_req   = state_q == CAPT;
    unique case (state_q)
      IDLE: if (in_valid) begin
        mul_a_d = in_a;
        mul_b_d = in_b;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_W'(MUL_LATENCY - 1)) ? CAPT : WAIT;
      end
      CAPT: state_d = cap_ok ? IDLE : CAPT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  mul_out_reg u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_req   (cap_req),
    .cap_d     (mul_s),
    .out_ready (out_ready),
    .cap_ok    (cap_ok),
    .out_valid (out_valid),
    .out_p     (out_p)
  );
endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb_booth_mul_sequencer: directed and randomized checks of the sequencer paired
// with a behavioural fixed-latency signed multiplier.
module tb_booth_mul_sequencer;
  import mul_pkg::*;
  localparam int NOPS = 1200;
  logic             clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic             in_ready, mul_start, out_valid, busy;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [PW-1:0]    mul_s = '0, out_p, mp = '0;
  int               mcnt = 0;
  int               checks = 0, failures = 0;

  booth_mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_s(mul_s), .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mulref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [PW-1:0] sa, sb;
    sa = $signed({{WIDTH{a[WIDTH-1]}}, a});
    sb = $signed({{WIDTH{b[WIDTH-1]}}, b});
    return sa * sb;
  endfunction

  // Multiplier stand-in: garbage until MUL_LATENCY edges after the start edge, then a*b held.
  always @(posedge clk) begin
    if (mul_start) begin
      mp    <= mulref(mul_a, mul_b);
      mul_s <= ~mulref(mul_a, mul_b);
      mcnt  <= 1;
    end else if (mcnt != 0) begin
      if (mcnt == MUL_LATENCY - 1) begin
        mul_s <= mp;
        mcnt  <= 0;
      end else mcnt <= mcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: return {1'b1, {(WIDTH-1){1'b0}}};
      1: return {1'b0, {(WIDTH-1){1'b1}}};
      2: return '0;
      3: return '1;
      default: return r[WIDTH-1:0];
    endcase
  endfunction

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", PW'(in_ready), PW'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", PW'(out_valid), PW'(1));
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [PW-1:0] e);
    send(a, b);
    wait_valid();
    chk(tag, out_p, e);
    @(negedge clk);
  endtask

  initial begin
    int               n, acc, got, cyc;
    logic             took, stall_prev;
    logic [PW-1:0]    prev_p, e;
    logic [PW-1:0]    q[$];
    #12;
    chk("rst_in_ready", PW'(in_ready), '0);
    chk("rst_mul_start", PW'(mul_start), '0);
    chk("rst_out_valid", PW'(out_valid), '0);
    chk("rst_busy", PW'(busy), '0);
    chk("rst_mul_a", PW'(mul_a), '0);
    chk("rst_out_p", out_p, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", PW'(in_ready), PW'(1));

    // First product latency, counted in edges from the accepting edge inclusive.
    out_ready = 1'b1;
    in_a = WIDTH'(3);
    in_b = -34'sd5;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) in_valid = 1'b0;
    end while (!out_valid && n < 100);
    chk("t1_latency", PW'(n), PW'(MUL_LATENCY + 2));
    chk("t1_p", out_p, 68'hFFFFFFFFFFFFFFFF1);
    chk("t1_busy", PW'(busy), '0);
    @(negedge clk);
    chk("t1_delivered", PW'(out_valid), '0);

    run_op("t2_min_min", 34'h200000000, 34'h200000000, 68'h40000000000000000);
    run_op("t2_max_min", 34'h1FFFFFFFF, 34'h200000000, 68'hC0000000200000000);

    // Backpressure with a second op stalled in capture.
    out_ready = 1'b0;
    send(WIDTH'(7), WIDTH'(6));
    wait_valid();
    chk("t3_first", out_p, PW'(42));
    send('1, '1);
    repeat (40) @(negedge clk);
    chk("t3_held", out_p, PW'(42));
    chk("t3_held_valid", PW'(out_valid), PW'(1));
    chk("t3_busy", PW'(busy), PW'(1));
    chk("t3_in_ready", PW'(in_ready), '0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_second", out_p, PW'(1));
    chk("t3_second_valid", PW'(out_valid), PW'(1));
    @(negedge clk);
    chk("t3_drained", PW'(out_valid), '0);

    // Operands stay latched while new offers arrive during the operation.
    send(WIDTH'(5), WIDTH'(7));
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_a = rnd_op();
      in_b = rnd_op();
      @(negedge clk);
      chk("t6_mul_a", PW'(mul_a), PW'(5));
      chk("t6_mul_b", PW'(mul_b), PW'(7));
    end
    in_valid = 1'b0;
    wait_valid();
    chk("t6_p", out_p, PW'(35));
    @(negedge clk);

    // Reset pulse mid-WAIT, off the clock edge.
    send(WIDTH'(9), WIDTH'(9));
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_in_ready", PW'(in_ready), '0);
    chk("t4_busy", PW'(busy), '0);
    chk("t4_out_valid", PW'(out_valid), '0);
    chk("t4_mul_a", PW'(mul_a), '0);
    chk("t4_out_p", out_p, '0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t4_no_stale", PW'(out_valid), '0);
    run_op("t4_after", WIDTH'(2), WIDTH'(3), PW'(6));

    // Randomized traffic against a queue of expected products.
    acc = 0; got = 0; cyc = 0; took = 1'b0; stall_prev = 1'b0; prev_p = '0;
    in_valid = 1'b0;
    while ((acc < NOPS || q.size() > 0) && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (stall_prev) chk("rnd_hold", out_p, prev_p);
      if (!(in_valid && !took)) begin
        in_valid = (acc < NOPS) && ($urandom_range(0, 2) != 0);
        in_a = rnd_op();
        in_b = rnd_op();
      end
      out_ready = $urandom_range(0, 3) != 0;
      if (out_valid && out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        chk("rnd_p", out_p, e);
        got++;
      end
      took = in_valid && in_ready;
      if (took) begin
        q.push_back(mulref(in_a, in_b));
        acc++;
      end
      stall_prev = out_valid && !out_ready;
      prev_p = out_p;
    end
    in_valid = 1'b0;
    chk("rnd_accepted", PW'(acc), PW'(NOPS));
    chk("rnd_delivered", PW'(got), PW'(NOPS));
    chk("rnd_left", PW'(q.size()), '0);
    repeat (40) @(negedge clk);
    chk("rnd_no_extra", PW'(out_valid), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
